jtframe_colmix_fade: RTL and testbench

JTFRAME_COLMIX_FADE -- requirements
Module: jtframe_colmix_fade

---
 rtl/jtframe_colmix_fade.sv | 203 ++++++++++++++++++++
 tb/tb_jtframe_colmix_fade.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_colmix_fade.sv
// rtl/jtframe_colmix_fade.sv - palette colour mixer with optional frame-paced brightness fade
//
// Optional feature macro: JTFRAME_COLMIX_FADE_EN (defined -> fade FSM and
// fade registers present; undefined -> brightness fixed at full scale).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pxl_cen             pixel clock enable
//   LHBL, LVBL          blanking inputs (active-low)
//   LHBL_dly, LVBL_dly  blanking delayed by DLY pxl_cen pulses
//   col_addr            pixel palette index
//   pal_cs, ctl_cs      palette / fade-register selects
//   cpu_rnw             1=read, 0=write
//   cpu_addr, cpu_dout  CPU byte address and write data
//   pal_dout            CPU read data (registered)
//   black_n             0 forces black
//   fade_busy           fade in progress
//   red, green, blue    colour outputs
module jtframe_colmix_fade #(
  parameter int AW  = 8,
  parameter int CW  = 4,
  parameter int DLY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  output logic          LHBL_dly,
  output logic          LVBL_dly,
  input  logic [AW-1:0] col_addr,
  input  logic          pal_cs,
  input  logic          ctl_cs,
  input  logic          cpu_rnw,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    pal_dout,
  input  logic          black_n,
  output logic          fade_busy,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue
);
  localparam int NE = 1 << AW;
  // Stages ahead of the output register; the output register is the last pulse.
  localparam int ND = DLY - 1;

  logic [7:0]    r_pal_lo [NE];
  logic [7:0]    r_pal_hi [NE];
  logic [AW-1:0] w_cpu_idx;
  logic          w_wr_lo, w_wr_hi;
  logic [3:0]    w_bright;
  logic [7:0]    w_ctl_rd;

  assign w_cpu_idx = cpu_addr[AW:1];
  assign w_wr_lo   = pal_cs & ~cpu_rnw & ~cpu_addr[0];
  assign w_wr_hi   = pal_cs & ~cpu_rnw &  cpu_addr[0];

  // Palette storage is never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_lo) r_pal_lo[w_cpu_idx] <= cpu_dout;
    if (w_wr_hi) r_pal_hi[w_cpu_idx] <= cpu_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_dout <= 8'd0;
    end else if (pal_cs & cpu_rnw) begin
      pal_dout <= cpu_addr[0] ? r_pal_hi[w_cpu_idx] : r_pal_lo[w_cpu_idx];
    end else if (ctl_cs & cpu_rnw) begin
      pal_dout <= w_ctl_rd;
    end
  end

`ifdef JTFRAME_COLMIX_FADE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STEP} state_t;
  state_t     r_state;
  logic [3:0] r_bright, r_target, r_rate, r_cnt, w_next;
  logic       r_busy, r_lvbl_prev, w_tick;

  // Frame tick: LVBL seen high on one pixel and low on the next.
  assign w_tick = pxl_cen & r_lvbl_prev & ~LVBL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_lvbl_prev <= 1'b0;
    else if (pxl_cen) r_lvbl_prev <= LVBL;
  end

  always_comb begin
    w_next = r_bright;
    if (r_bright < r_target)      w_next = r_bright + 4'd1;
    else if (r_bright > r_target) w_next = r_bright - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bright <= 4'hf;
      r_target <= 4'hf;
      r_rate   <= 4'd0;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
    end else begin
      // Register writes never touch the counter, so a new target only
      // redirects the next step.
      if (ctl_cs & ~cpu_rnw) begin
        if (cpu_addr[0]) r_rate   <= cpu_dout[3:0];
        else             r_target <= cpu_dout[3:0];
      end
      case (r_state)
        ST_IDLE: if (r_bright != r_target) begin
          r_state <= ST_WAIT;
          r_cnt   <= r_rate;
          r_busy  <= 1'b1;
        end
        ST_WAIT: if (w_tick) begin
          if (r_cnt == 4'd0) r_state <= ST_STEP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_STEP: begin
          r_bright <= w_next;
          if (w_next == r_target) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= r_rate;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_bright  = r_bright;
  assign fade_busy = r_busy;
  assign w_ctl_rd  = {r_target, r_rate};
`else
  assign w_bright  = 4'hf;
  assign fade_busy = 1'b0;
  assign w_ctl_rd  = 8'd0;
`endif

  // (c * (bright+1)) >> 4 at CW+4 bits; bright 15 is identity.
  function automatic logic [CW-1:0] f_scale(input logic [CW-1:0] c, input logic [3:0] b);
    logic [CW+3:0] p;
    p = {4'd0, c} * ({{CW{1'b0}}, b} + (CW+4)'(1));
    return (b == 4'd0) ? '0 : p[CW+3:4];
  endfunction

  logic [15:0]   r_word [ND];
  logic [ND-1:0] r_hb, r_vb, r_bn;
  logic [15:0]   w_last;
  logic [CW-1:0] w_r, w_g, w_b;
  logic          w_show;

  assign w_last = r_word[ND-1];
  assign w_show = r_hb[ND-1] & r_vb[ND-1] & r_bn[ND-1];

  generate
    if (CW == 4) begin : g_cw4
      assign w_r = w_last[7:4];
      assign w_g = w_last[3:0];
      assign w_b = w_last[15:12];
    end else begin : g_cw5
      assign w_r = w_last[14:10];
      assign w_g = w_last[9:5];
      assign w_b = w_last[4:0];
    end
  endgenerate

  // black_n travels with the pixel so it lines up with the delayed blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ND; i++) r_word[i] <= 16'd0;
      r_hb     <= '0;
      r_vb     <= '0;
      r_bn     <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else if (pxl_cen) begin
      r_word[0] <= {r_pal_hi[col_addr], r_pal_lo[col_addr]};
      r_hb[0]   <= LHBL;
      r_vb[0]   <= LVBL;
      r_bn[0]   <= black_n;
      for (int i = 1; i < ND; i++) begin
        r_word[i] <= r_word[i-1];
        r_hb[i]   <= r_hb[i-1];
        r_vb[i]   <= r_vb[i-1];
        r_bn[i]   <= r_bn[i-1];
      end
      LHBL_dly <= r_hb[ND-1];
      LVBL_dly <= r_vb[ND-1];
      red      <= w_show ? f_scale(w_r, w_bright) : '0;
      green    <= w_show ? f_scale(w_g, w_bright) : '0;
      blue     <= w_show ? f_scale(w_b, w_bright) : '0;
    end
  end

endmodule

// File: tb/tb_jtframe_colmix_fade.sv
// tb/tb_jtframe_colmix_fade.sv - scoreboard bench for jtframe_colmix_fade (CW=4/DLY=2 and CW=5/DLY=3)
module tb_jtframe_colmix_fade;
  logic       clk = 0, rst = 1, pxl_cen = 0, LHBL = 0, LVBL = 0, black_n = 1;
  logic [7:0] col_addr = 0, cpu_dout = 0;
  logic       pal_cs = 0, ctl_cs = 0, cpu_rnw = 1;
  logic [8:0] cpu_addr = 0;
  logic       lh4, lv4, fb4, lh5, lv5, fb5;
  logic [7:0] pd4, pd5;
  logic [3:0] r4, g4, b4;
  logic [4:0] r5, g5, b5;

  always #5 clk = ~clk;

  jtframe_colmix_fade #(.AW(8), .CW(4), .DLY(2)) u_dut4 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .LHBL_dly(lh4), .LVBL_dly(lv4), .col_addr(col_addr), .pal_cs(pal_cs),
    .ctl_cs(ctl_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .pal_dout(pd4), .black_n(black_n), .fade_busy(fb4),
    .red(r4), .green(g4), .blue(b4));

  jtframe_colmix_fade #(.AW(8), .CW(5), .DLY(3)) u_dut5 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .LHBL_dly(lh5), .LVBL_dly(lv5), .col_addr(col_addr), .pal_cs(pal_cs),
    .ctl_cs(ctl_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .pal_dout(pd5), .black_n(black_n), .fade_busy(fb5),
    .red(r5), .green(g5), .blue(b5));

  typedef struct packed {
    logic [15:0] w;
    logic        hb;
    logic        vb;
    logic        bn;
  } pix_t;

  pix_t       q4[$], q5[$];
  logic [7:0] m_lo [256], m_hi [256];
  int         m_bright = 15, ticks = 0;
  int         n_chk = 0, n_pass = 0;
  logic       coll_en = 0;
  logic [7:0] coll_data = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [4:0] f_sc(input logic [4:0] c, input int br);
    int p;
    if (br == 0) return 5'd0;
    p = int'(c) * (br + 1);
    return 5'(p >> 4);
  endfunction

  function automatic logic [16:0] f_exp(input pix_t p, input int cw, input int br);
    logic [4:0] r, g, b;
    if (cw == 4) begin
      r = {1'b0, p.w[7:4]}; g = {1'b0, p.w[3:0]}; b = {1'b0, p.w[15:12]};
    end else begin
      r = p.w[14:10]; g = p.w[9:5]; b = p.w[4:0];
    end
    r = f_sc(r, br); g = f_sc(g, br); b = f_sc(b, br);
    if (!(p.hb && p.vb && p.bn)) begin r = 0; g = 0; b = 0; end
    return {r, g, b, p.hb, p.vb};
  endfunction

  // Pipelines are cleared by reset: the first DLY-1 outputs are blank.
  task automatic prefill();
    pix_t z;
    z = '0;
    q4.delete(); q5.delete();
    q4.push_back(z);
    repeat (2) q5.push_back(z);
  endtask

  task automatic pix(input logic [7:0] a, input logic hb, input logic vb, input logic bn);
    pix_t p, o;
    col_addr = a; LHBL = hb; LVBL = vb; black_n = bn;
    p.w = {m_hi[a], m_lo[a]}; p.hb = hb; p.vb = vb; p.bn = bn;
    q4.push_back(p); q5.push_back(p);
    if (coll_en) begin
      pal_cs = 1; cpu_rnw = 0; cpu_addr = {a, 1'b0}; cpu_dout = coll_data;
      m_lo[a] = coll_data;
    end
    pxl_cen = 1;
    @(negedge clk);
    pxl_cen = 0; pal_cs = 0; cpu_rnw = 1; coll_en = 0;
    if (q4.size() == 0 || q5.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      o = q4.pop_front();
      chk("rgb4", {1'b0, r4, 1'b0, g4, 1'b0, b4, lh4, lv4}, 32'(f_exp(o, 4, m_bright)));
      o = q5.pop_front();
      chk("rgb5", {r5, g5, b5, lh5, lv5}, 32'(f_exp(o, 5, m_bright)));
    end
    @(negedge clk);
  endtask

  task automatic cpu_wr(input logic ctl, input logic [8:0] ad, input logic [7:0] d);
    pal_cs = !ctl; ctl_cs = ctl; cpu_rnw = 0; cpu_addr = ad; cpu_dout = d;
    if (!ctl) begin
      if (ad[0]) m_hi[ad[8:1]] = d;
      else       m_lo[ad[8:1]] = d;
    end
    @(negedge clk);
    pal_cs = 0; ctl_cs = 0; cpu_rnw = 1;
  endtask

  task automatic cpu_rd(input logic ctl, input logic [8:0] ad, input logic [7:0] exp, input string tag);
    pal_cs = !ctl; ctl_cs = ctl; cpu_rnw = 1; cpu_addr = ad;
    @(negedge clk);
    pal_cs = 0; ctl_cs = 0;
    chk({tag, "_4"}, pd4, exp);
    chk({tag, "_5"}, pd5, exp);
    @(negedge clk);
    chk({tag, "_hold"}, pd4, exp);
  endtask

  task automatic frame(input logic [7:0] a);
    pix(a, 1, 1, 1);
    pix(8'h09, 1, 1, 1);
    pix(a, 1, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_out4", {r4, g4, b4, lh4, lv4}, 0);
    chk("rst_out5", {r5, g5, b5, lh5, lv5}, 0);
    chk("rst_pd", {pd4, pd5}, 0);
    chk("rst_busy", {fb4, fb5}, 0);
    rst = 0;
    prefill();

    for (int i = 0; i < 32; i++) begin
      cpu_wr(0, {8'(i), 1'b0}, 8'($urandom));
      cpu_wr(0, {8'(i), 1'b1}, 8'($urandom));
    end
    cpu_wr(0, 9'h010, 8'h3C);
    cpu_wr(0, 9'h011, 8'hA5);
    cpu_wr(0, 9'h012, 8'hFF);
    cpu_wr(0, 9'h013, 8'h7F);

    pix(8'h08, 1, 1, 1);
    pix(8'h09, 1, 1, 1);
    pix(8'h08, 1, 1, 1);
    pix(8'h08, 0, 1, 1);
    pix(8'h08, 1, 0, 1);
    pix(8'h09, 1, 1, 0);
    pix(8'h09, 1, 1, 1);
    pix(8'h08, 1, 1, 1);
    for (int i = 0; i < 24; i++)
      pix(8'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0);
    pix(8'h08, 1, 1, 1);

    coll_en = 1; coll_data = 8'h5A;
    pix(8'h10, 1, 1, 1);
    pix(8'h10, 1, 1, 1);
    pix(8'h08, 1, 1, 1);

    cpu_rd(0, 9'h011, 8'hA5, "rd_hi");
    cpu_rd(0, 9'h010, 8'h3C, "rd_lo");

`ifdef JTFRAME_COLMIX_FADE_EN
    cpu_wr(1, 9'h001, 8'h01);
    cpu_wr(1, 9'h000, 8'h00);
    cpu_rd(1, 9'h000, 8'h01, "ctl_rd");
    chk("busy_start", {fb4, fb5}, 2'b11);
    ticks = 0;
    for (int f = 0; f < 30; f++) begin
      frame(8'h08);
      ticks++;
      m_bright = 15 - ticks / 2;
      chk("busy_dn", {fb4, fb5}, (ticks < 30) ? 2'b11 : 2'b00);
    end
    pix(8'h08, 1, 1, 1);
    pix(8'h09, 1, 1, 1);
    pix(8'h09, 1, 1, 1);
    pix(8'h09, 1, 1, 1);

    cpu_wr(1, 9'h001, 8'h00);
    cpu_wr(1, 9'h000, 8'h07);
    ticks = 0;
    for (int f = 0; f < 7; f++) begin
      frame(8'h08);
      ticks++;
      m_bright = ticks;
      chk("busy_up", {fb4, fb5}, (ticks < 7) ? 2'b11 : 2'b00);
    end
    pix(8'h09, 1, 1, 1);
    pix(8'h09, 1, 1, 1);
    pix(8'h09, 1, 1, 1);
    chk("cw5_b7", {r5, g5, b5}, {5'd15, 5'd15, 5'd15});

    cpu_wr(1, 9'h001, 8'h03);
    cpu_wr(1, 9'h000, 8'h00);
    @(negedge clk);
    chk("busy_mid", {fb4, fb5}, 2'b11);
    rst = 1;
    #1;
    chk("rst_busy_async", {fb4, fb5}, 0);
    chk("rst_rgb_async", {r4, g4, b4, lh4, lv4}, 0);
    @(negedge clk);
    rst = 0;
    m_bright = 15;
    prefill();
    cpu_rd(1, 9'h000, 8'hF0, "ctl_rst");
`else
    cpu_wr(1, 9'h000, 8'h00);
    cpu_wr(1, 9'h001, 8'h01);
    @(negedge clk);
    chk("busy_off", {fb4, fb5}, 0);
    cpu_rd(1, 9'h000, 8'h00, "ctl_rd");
    for (int f = 0; f < 4; f++) begin
      frame(8'h08);
      chk("busy_off_f", {fb4, fb5}, 0);
    end
    rst = 1;
    #1;
    chk("rst_rgb_async", {r4, g4, b4, lh4, lv4}, 0);
    chk("rst_busy_async", {fb4, fb5}, 0);
    @(negedge clk);
    rst = 0;
    prefill();
`endif

    pix(8'h08, 1, 1, 1);
    pix(8'h09, 1, 1, 1);
    pix(8'h08, 1, 1, 1);
    pix(8'h08, 1, 1, 1);
    chk("rgb_3ca", {r4, g4, b4}, 12'h3CA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
